// File: rtl/mac_exec_unit.sv
// Multiply-accumulate execution stage: accepts {a, b, c}, computes a*b + c with a
// bit-serial shift-add multiplier, then holds the result on a valid/ready handshake.
module mac_exec_unit #(
    parameter int DATA_W   = 20,
    parameter int W_DATA_W = 2 * DATA_W
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic [DATA_W-1:0]   operand_a_i,
    input  logic [DATA_W-1:0]   operand_b_i,
    input  logic [W_DATA_W-1:0] operand_c_i,
    input  logic                operation_valid_i,
    output logic                operation_ready_o,
    output logic [W_DATA_W-1:0] result_o,
    output logic                overflow_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic                overrun_o
);

    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [W_DATA_W-1:0] w_data_t;

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    w_data_t           a_sh;
    w_data_t           c_reg;
    w_data_t           acc;
    data_t             b_reg;
    logic [CNT_W-1:0]  cnt;
    logic [W_DATA_W:0] sum;
    logic              mul_last;

    assign mul_last = (cnt == CNT_W'(DATA_W - 1));
    assign sum      = {1'b0, acc} + {1'b0, c_reg};

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        operation_ready_o = 1'b0;
        case (state)
            IDLE: begin
                operation_ready_o = 1'b1;
                if (operation_valid_i) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (result_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // a is kept pre-shifted so each MUL step is a plain conditional add
    always_ff @(posedge clk) begin
        if (rst_i) begin
            a_sh           <= '0;
            b_reg          <= '0;
            c_reg          <= '0;
            acc            <= '0;
            cnt            <= '0;
            result_o       <= '0;
            overflow_o     <= 1'b0;
            result_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            if (operation_valid_i && (state != IDLE)) begin
                overrun_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (operation_valid_i) begin
                        a_sh  <= w_data_t'(operand_a_i);
                        b_reg <= operand_b_i;
                        c_reg <= operand_c_i;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    if (b_reg[0]) begin
                        acc <= acc + a_sh;
                    end
                    a_sh  <= a_sh << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                ADD: begin
                    result_o       <= sum[W_DATA_W-1:0];
                    overflow_o     <= sum[W_DATA_W];
                    result_valid_o <= 1'b1;
                end
                HOLD: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mac_exec_unit.md
# mac_exec_unit

Operand execution stage placed directly downstream of the receive FSM. It consumes the assembled operand triple `{a, b, c}` on `operation_valid_i` and computes the unsigned multiply-accumulate `a*b + c` with a bit-serial shift-add multiplier. It presents the result to the downstream send/transmit stage over a valid/ready handshake. The upstream stage has no backpressure, so the block flags any operation that arrives while it is busy.

## Interface
- `DATA_W`, 20: width of operands a and b (`data_t`).
- `W_DATA_W`, `2*DATA_W`: width of operand c and of the result (`w_data_t`).
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_i` input 1: reset. Synchronous, active-high.
- `operand_a_i` input DATA_W: multiplicand, unsigned.
- `operand_b_i` input DATA_W: multiplier, unsigned.
- `operand_c_i` input W_DATA_W: addend, unsigned.
- `operation_valid_i` input 1: single-cycle pulse meaning the operand triple is valid.
- `operation_ready_o` output 1: high when the block is in IDLE and will accept an operation.
- `result_o` output W_DATA_W: `(a*b + c) mod 2^W_DATA_W`.
- `overflow_o` output 1: carry out of the final addition. Valid together with `result_o`.
- `result_valid_o` output 1: result available.
- `result_ready_i` input 1: downstream accepts the result.
- `overrun_o` output 1: sticky flag. An operation was dropped because the block was busy.

## Operation
- States are IDLE, MUL, ADD and HOLD. Reset, or any `rst_i=1` edge, forces:
  - state to IDLE,
  - all internal registers to 0,
  - `result_o=0`, `overflow_o=0`, `result_valid_o=0`, `overrun_o=0`, `operation_ready_o=1` (combinational from IDLE).
- IDLE:
  - On `operation_valid_i=1`, latch a, b and c, clear the accumulator and counter, and go to MUL.
- MUL runs for exactly DATA_W cycles, step i = 0..DATA_W-1:
  - If `b_reg[0]`, then `acc += a_reg << i`. Equivalently, add a shifted-a register and then shift it left by 1.
  - Shift `b_reg` right by 1.
  - Increment the counter.
  - After step DATA_W-1, go to ADD.
  - acc is W_DATA_W wide. The product never exceeds 2^W_DATA_W − 1, so there is no loss in MUL.
- ADD (one cycle):
  - `{overflow, sum} = acc + c_reg`, computed W_DATA_W+1 wide.
  - Register `result_o = sum[W_DATA_W-1:0]` and `overflow_o = carry`.
  - Set `result_valid_o=1` and go to HOLD.
- HOLD:
  - `result_o`, `overflow_o` and `result_valid_o` stay stable until `result_ready_i=1` is sampled.
  - On that edge, clear `result_valid_o` and go to IDLE.
  - `result_o` and `overflow_o` keep their last values; they are don't-care while `result_valid_o=0`.
- Overrun:
  - `operation_valid_i=1` in any state other than IDLE is dropped.
  - The in-flight operation is unaffected.
  - `overrun_o` is set on the next edge and remains set until `rst_i`.
- Operands are sampled only at the accepting edge. Input changes afterwards have no effect.
- Simultaneous `rst_i` and `operation_valid_i`: reset wins and the operation is not accepted.

## Timing
- The accepting edge is E0, i.e. IDLE with `operation_valid_i=1`.
- MUL steps occur at edges E1..E_DATA_W.
- ADD occurs at E_DATA_W+1.
- `result_valid_o` is high after E_DATA_W+1, which is 21 cycles with defaults.
- Handshake completes at the first edge with `result_valid_o & result_ready_i`. `operation_ready_o` is high in the following cycle.
- Minimum issue interval with `result_ready_i` tied high:
  - DATA_W+3 cycles, which is 23.
  - Built from 1 accept cycle, DATA_W MUL cycles, 1 ADD cycle and 1 HOLD cycle.
- `operation_ready_o` is low from the cycle after E0 until the cycle after the handshake.
- Reset mid-operation (MUL, ADD or HOLD) aborts without producing a result. The block is in IDLE after the reset edge.

## Test plan
- Basic: a=3, b=5, c=7 with `result_ready_i=1` → `result_o=22` and `overflow_o=0`. `result_valid_o` rises 21 cycles after the accepting edge and stays high for 1 cycle.
- Extremes:
  - a=b=0xFFFFF, c=0xFF_FFFF_FFFF → `result_o=0xFF_FFE0_0000`, `overflow_o=1`.
  - a=0xABCDE, b=0, c=0x12345 → `result_o=0x12345`, `overflow_o=0`.
- Backpressure: hold `result_ready_i=0` for 10 cycles after valid → `result_o` and `result_valid_o` stay stable and `operation_ready_o=0`. Raise ready → valid drops at the next edge and `operation_ready_o=1` one cycle later.
- Overrun: pulse a second `operation_valid_i` 5 cycles after the first →
  - the first result is still correct,
  - the second operation is not executed,
  - `overrun_o=1` and stays set until `rst_i`.
- Reset mid-MUL: assert `rst_i` for 1 cycle at step 10 → all outputs 0 and `operation_ready_o=1`. A new operation a=2, b=2, c=0 then gives `result_o=4`.
- Back-to-back: issue 3 operations every 23 cycles with ready high → 3 correct results in order and `overrun_o=0`.
